// File: rtl/fft_stream_pkg.sv
// Shared types and constants for the FFT frame streaming path.
package fft_stream_pkg;

    localparam int DATA_W    = 24;
    localparam int FRAME_LEN = 1024;

    localparam logic [1:0] SINK_ERROR_CODE = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_e;

endpackage

// File: rtl/fft_frame_source_if.sv
// Sink-side streaming bus toward the FFT core (valid/ready with frame markers).
interface fft_frame_source_if #(
    parameter int DATA_W = fft_stream_pkg::DATA_W
);
    logic              sink_valid;
    logic              sink_ready;
    logic              sink_sop;
    logic              sink_eop;
    logic [DATA_W-1:0] sink_real;
    logic [DATA_W-1:0] sink_imag;
    logic [1:0]        sink_error;

    modport master (
        output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
        input  sink_ready
    );

    modport slave (
        input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
        output sink_ready
    );
endinterface

// File: rtl/fft_frame_source_sample_fifo.sv
// sample_fifo: synchronous show-ahead FIFO; the head word is held in a register
// so the read data stays at its last value while the FIFO is empty.
module sample_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              empty_nxt
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              do_wr_s, do_rd_s;

    // Next pointers, flags and head word; a full FIFO rejects writes even when popped.
    always_comb begin
        do_wr_s = wr_en && !full_q;
        do_rd_s = rd_en && !empty_q;
        if (do_wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_rd_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
        head_d  = head_q;
        if (!empty_d) begin
            // The incoming word becomes the head when nothing else is queued ahead of it.
            if (do_wr_s && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                head_d = wr_data;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end else begin
            head_d = head_q;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Pointer, flag and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    assign rd_data   = head_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign empty_nxt = empty_d;

endmodule

// File: rtl/fft_frame_source.sv
// fft_frame_source: buffers strobed audio samples and streams them to an FFT
// core as whole frames of FRAME_LEN samples marked with sop/eop.
module fft_frame_source #(
    parameter int DATA_W     = fft_stream_pkg::DATA_W,
    parameter int FRAME_LEN  = fft_stream_pkg::FRAME_LEN,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               MCLK,
    input  logic               reset,
    input  logic               enable,
    input  logic [DATA_W-1:0]  sample_in,
    input  logic               sample_valid,
    fft_frame_source_if.master sink,
    output logic               overflow,
    output logic [15:0]        frame_count
);
    import fft_stream_pkg::*;

    localparam int IDX_W = $clog2(FRAME_LEN);

    state_e            state_q, state_d;
    logic              rst_sync_q, rst_sync_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;

    logic              fifo_wr_s;
    logic              xfer_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              fifo_empty_nxt_s;
    logic [DATA_W-1:0] fifo_head_s;

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_sample_fifo (
        .clk       (MCLK),
        .rst_n     (reset),
        .wr_en     (fifo_wr_s),
        .wr_data   (sample_in),
        .rd_en     (xfer_s),
        .rd_data   (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .empty_nxt (fifo_empty_nxt_s)
    );

    // Frame-level control: write admission, state sequencing and read-side framing.
    always_comb begin
        rst_sync_d    = 1'b1;
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        overflow_d    = overflow_q;
        fifo_wr_s     = 1'b0;
        xfer_s        = !fifo_empty_s && sink.sink_ready;
        case (state_q)
            IDLE: begin
                // rst_sync_q holds the FSM for one edge after reset release.
                if (rst_sync_q && enable) begin
                    state_d    = RUN;
                    overflow_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // Leaving only at a frame boundary keeps partial frames out of the FIFO.
                if (!enable && (wr_idx_q == '0)) begin
                    state_d = DRAIN;
                end else if (sample_valid) begin
                    if (!fifo_full_s) begin
                        fifo_wr_s = 1'b1;
                        wr_idx_d  = wr_idx_q + IDX_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (fifo_empty_nxt_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (xfer_s) begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
        end else begin
            rd_idx_d = rd_idx_q;
        end
        if (xfer_s && eop_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
        sop_d = !fifo_empty_nxt_s && (rd_idx_d == '0);
        eop_d = !fifo_empty_nxt_s && (rd_idx_d == IDX_W'(FRAME_LEN - 1));
    end

    // Control and output registers.
    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            rst_sync_q    <= 1'b0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            overflow_q    <= 1'b0;
            frame_count_q <= 16'd0;
            sop_q         <= 1'b0;
            eop_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_sync_q    <= rst_sync_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            overflow_q    <= overflow_d;
            frame_count_q <= frame_count_d;
            sop_q         <= sop_d;
            eop_q         <= eop_d;
        end
    end

    assign sink.sink_valid = !fifo_empty_s;
    assign sink.sink_real  = fifo_head_s;
    assign sink.sink_sop   = sop_q;
    assign sink.sink_eop   = eop_q;
    assign sink.sink_imag  = '0;
    assign sink.sink_error = SINK_ERROR_CODE;
    assign overflow        = overflow_q;
    assign frame_count     = frame_count_q;

endmodule

// File: doc/fft_frame_source.md
FFT_FRAME_SOURCE -- requirements
Module: fft_frame_source

Interface
REQ-001 Parameter DATA_W, default 24: sample width in bits.
REQ-002 Parameter FRAME_LEN, default 1024: samples per FFT frame; must be a power of two.
REQ-003 Parameter FIFO_DEPTH, default 16: sample buffer entries; must be a power of two.
REQ-004 Port MCLK, input, 1 bit: the single clock (50 MHz board clock); every register is clocked on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port enable, input, 1 bit: streaming request.
REQ-007 Port sample_in, input, DATA_W bits: signed audio sample.
REQ-008 Port sample_valid, input, 1 bit: one-cycle strobe, one per audio sample period.
REQ-009 Port sink_ready, input, 1 bit: FFT core is ready to accept data.
REQ-010 Port sink_valid, output, 1 bit: sink_real is valid.
REQ-011 Port sink_sop, output, 1 bit: first sample of a frame.
REQ-012 Port sink_eop, output, 1 bit: last sample of a frame.
REQ-013 Port sink_real, output, DATA_W bits: sample to the FFT core.
REQ-014 Port sink_imag, output, DATA_W bits: constant zero.
REQ-015 Port sink_error, output, 2 bits: constant 2'b00.
REQ-016 Port overflow, output, 1 bit: sticky flag, set when a sample is dropped.
REQ-017 Port frame_count, output, 16 bits: number of completed frames; wraps modulo 2^16.

Function
REQ-018 A transfer SHALL occur on any cycle where sink_valid and sink_ready are both high; ready latency is 0.
REQ-019 The state machine SHALL have three states: IDLE, RUN and DRAIN.
REQ-020 IDLE: writes are blocked; enable=1 moves to RUN on the next cycle and clears overflow.
REQ-021 RUN, write side: a write is accepted when sample_valid=1 and the FIFO is not full.
REQ-022 RUN, write index: wr_idx (0..FRAME_LEN-1) increments on each accepted write and wraps to 0.
REQ-023 RUN, exit: with enable=0, the state moves to DRAIN once wr_idx==0, so no partial frame is ever written; it stays in RUN while wr_idx!=0.
REQ-024 DRAIN: writes are blocked; the state moves to IDLE on the cycle the FIFO becomes empty.
REQ-025 Read side, all states: sink_valid = FIFO not empty; sink_real = FIFO head (show-ahead).
REQ-026 Read side, pointer: the FIFO head advances on each transfer.
REQ-027 rd_idx (0..FRAME_LEN-1) SHALL increment per transfer and wrap to 0.
REQ-028 sink_sop SHALL equal sink_valid AND rd_idx==0.
REQ-029 sink_eop SHALL equal sink_valid AND rd_idx==FRAME_LEN-1.
REQ-030 frame_count SHALL increment on each transfer with sink_eop=1.
REQ-031 Write-to-sink_valid latency SHALL be 1 cycle when the FIFO is empty.
REQ-032 Full FIFO: a write is rejected even if a read occurs in the same cycle; the sample is dropped, overflow is set, and wr_idx does not advance.
REQ-033 Empty FIFO: sink_valid=0 and sink_real holds its last value; rd_idx is unchanged.
REQ-034 Simultaneous write and read on a non-empty, non-full FIFO SHALL leave occupancy unchanged.
REQ-035 enable toggling while in DRAIN SHALL be ignored until IDLE is reached.

Reset
REQ-036 While reset=0, all state SHALL clear asynchronously: state=IDLE, FIFO empty, wr_idx=0, rd_idx=0.
REQ-037 While reset=0, all outputs SHALL clear: sink_valid, sink_sop, sink_eop, overflow and frame_count are 0, and sink_real is 0.
REQ-038 Reset asserted mid-frame SHALL discard the partial frame; the first transfer after reset is flagged sink_sop.
REQ-039 Reset release SHALL be used synchronously; the first state change is allowed on the second rising edge of MCLK after release.

Structure
REQ-040 Shared package fft_stream_pkg SHALL hold DATA_W, FRAME_LEN, the state enum (IDLE, RUN, DRAIN) and the sink_error code constant.
REQ-041 The block SHALL instantiate one sub-module, sample_fifo: synchronous, show-ahead, with full and empty outputs, reset on reset.
REQ-042 Index widths SHALL be log2(FRAME_LEN) bits for wr_idx and rd_idx and log2(FIFO_DEPTH)+1 bits for the FIFO pointers.

Verification
REQ-043 FRAME_LEN=8, enable=1, sink_ready=1, 8 strobes every 4 cycles -> 8 transfers; sop on sample 0 and eop on sample 7; frame_count=1; sink_imag=0.
REQ-044 sink_ready=0 for 20 cycles, FIFO_DEPTH=16, 18 strobes -> first 16 stored, overflow=1, 16 transfers when ready returns; eop index accounts for the 2 dropped samples.
REQ-045 enable dropped after sample 3 of an 8-sample frame -> samples 4..7 still accepted; the frame ends with eop; state goes RUN->DRAIN->IDLE; later strobes are ignored.
REQ-046 reset pulsed low after transfer 5 of a frame -> all outputs 0 immediately; after re-enable the next transfer has sop=1 and frame_count=0.
REQ-047 sink_ready toggling every cycle over 3 frames -> no lost or duplicated samples (scoreboard); frame_count=3; sop/eop exactly on indices 0 and 7.
